pipe_ctrl: RTL and testbench

Pipeline sequencer and hazard controller for the 5-stage 16-bit processor. It takes the processor from idle to running and generates the fetch/decode enables and the per-register write/bubble controls for IF/ID, ID/EX, EX/MEM and MEM/WB. It also inserts load-use stalls, suppresses the immediate word of two-word LDM instructions, and drains the pipeline on HLT. It sits in the processor top level and replaces the hard-wired enables.

---
 rtl/pipe_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer and load-use hazard controller for the 5-stage 16-bit core.
// Drives per-stage enables, ID/EX bubbles, LDM immediate suppression and HLT drain.
module pipe_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt,
  input  logic             ldm,
  input  logic             ex_mem_read,
  input  logic             ex_rw,
  input  logic [2:0]       ex_rd,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  output logic             fetch_enable,
  output logic             decode_enable,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             idex_bubble,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {StIdle, StRun, StImm, StDrain, StHalted} state_e;

  state_e             state_q;
  logic [3:0]         drain_q;
  logic [CNT_W-1:0]   stall_q;
  logic               hazard;

  assign hazard = ex_mem_read & ex_rw &
                  ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      drain_q <= '0;
      stall_q <= '0;
    end else begin
      case (state_q)
        StIdle, StHalted: begin
          if (start) state_q <= StRun;
        end
        StRun: begin
          if (halt) begin
            drain_q <= 4'(DRAIN_CYCLES - 1);
            state_q <= StDrain;
          end else if (hazard) begin
            if (stall_q != '1) stall_q <= stall_q + 1'b1;
          end else if (ldm) begin
            state_q <= StImm;
          end
        end
        StImm: state_q <= StRun;
        StDrain: begin
          if (drain_q == 4'd0) state_q <= StHalted;
          else                 drain_q <= drain_q - 4'd1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs follow the inputs in the same cycle so stalls take effect immediately.
  always_comb begin
    fetch_enable  = 1'b0;
    decode_enable = 1'b0;
    ifid_we       = 1'b0;
    idex_we       = 1'b0;
    idex_bubble   = 1'b0;
    exmem_we      = 1'b0;
    memwb_we      = 1'b0;
    running       = 1'b0;
    done          = 1'b0;
    stall_cnt     = '0;
    if (!rst) begin
      stall_cnt = stall_q;
      case (state_q)
        StRun: begin
          running       = 1'b1;
          decode_enable = 1'b1;
          idex_we       = 1'b1;
          exmem_we      = 1'b1;
          memwb_we      = 1'b1;
          if (halt || hazard) begin
            idex_bubble = 1'b1;
          end else begin
            fetch_enable = 1'b1;
            ifid_we      = 1'b1;
          end
        end
        StImm: begin
          running       = 1'b1;
          fetch_enable  = 1'b1;
          decode_enable = 1'b1;
          ifid_we       = 1'b1;
          idex_we       = 1'b1;
          idex_bubble   = 1'b1;
          exmem_we      = 1'b1;
          memwb_we      = 1'b1;
        end
        StDrain: begin
          decode_enable = 1'b1;
          idex_we       = 1'b1;
          idex_bubble   = 1'b1;
          exmem_we      = 1'b1;
          memwb_we      = 1'b1;
        end
        StHalted: done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random stimulus, each cycle's
// expected outputs come from a cycle-level behavioural model and are checked by a monitor.
module tb_pipe_ctrl;

  localparam int DC   = 3;
  localparam int CW   = 2;
  localparam int SMAX = (1 << CW) - 1;
  localparam int OW   = 9 + CW;

  localparam int M_IDLE = 0, M_RUN = 1, M_IMM = 2, M_DRAIN = 3, M_HALTED = 4;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, halt = 1'b0, ldm = 1'b0;
  logic ex_mem_read = 1'b0, ex_rw = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic [2:0] ex_rd = '0, id_rs = '0, id_rt = '0;
  logic fetch_enable, decode_enable, ifid_we, idex_we, idex_bubble, exmem_we, memwb_we;
  logic running, done;
  logic [CW-1:0] stall_cnt;

  pipe_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .ldm(ldm),
    .ex_mem_read(ex_mem_read), .ex_rw(ex_rw), .ex_rd(ex_rd),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .fetch_enable(fetch_enable), .decode_enable(decode_enable), .ifid_we(ifid_we),
    .idex_we(idex_we), .idex_bubble(idex_bubble), .exmem_we(exmem_we),
    .memwb_we(memwb_we), .running(running), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] v;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   stim_done = 1'b0;

  // Behavioural model state
  int mode = M_IDLE;
  int drain_left = 0;
  int stalls = 0;

  task automatic step(input bit r, input bit s, input bit h, input bit l,
                      input bit mr, input bit rw, input int rd, input int rs, input int rt,
                      input bit urs, input bit urt);
    bit f, d, i, x, b, em, mw, rn, dn, hz;
    int sc, nxt;
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; start = s; halt = h; ldm = l; ex_mem_read = mr; ex_rw = rw;
    ex_rd = 3'(rd); id_rs = 3'(rs); id_rt = 3'(rt); id_use_rs = urs; id_use_rt = urt;
    {f, d, i, x, b, em, mw, rn, dn} = '0;
    sc = 0;
    if (r) begin
      mode = M_IDLE; drain_left = 0; stalls = 0;
    end else begin
      hz  = mr && rw && ((urs && rs == rd) || (urt && rt == rd));
      sc  = stalls;
      nxt = mode;
      rn  = (mode == M_RUN) || (mode == M_IMM);
      dn  = (mode == M_HALTED);
      case (mode)
        M_IDLE, M_HALTED: if (s) nxt = M_RUN;
        M_RUN: begin
          if (h || hz) begin
            {f, i, x, b, em, mw, d} = 7'b0011111;
            if (h) begin
              drain_left = DC;
              nxt = M_DRAIN;
            end else if (stalls < SMAX) begin
              stalls++;
            end
          end else begin
            {f, d, i, x, em, mw} = '1;
            if (l) nxt = M_IMM;
          end
        end
        M_IMM: begin
          {f, d, i, x, b, em, mw} = '1;
          nxt = M_RUN;
        end
        default: begin // drain: one cycle per stage still completing
          {f, i, x, b, em, mw, d} = 7'b0011111;
          drain_left--;
          if (drain_left == 0) nxt = M_HALTED;
        end
      endcase
      mode = nxt;
    end
    e.v   = {f, d, i, x, b, em, mw, rn, dn, CW'(sc)};
    e.cyc = cyc;
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic idle_step(input bit s);
    step(1'b0, s, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic hz_step(input bit h, input bit l);
    step(1'b0, 1'b0, h, l, 1'b1, 1'b1, 3, 3, 5, 1'b1, 1'b0);
  endtask

  // Monitor: the DUT presents a full output word every cycle
  initial begin
    exp_t e;
    logic [OW-1:0] got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {fetch_enable, decode_enable, ifid_we, idex_we, idex_bubble, exmem_we,
               memwb_we, running, done, stall_cnt};
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL outputs cycle %0d: got %b required %b", e.cyc, got, e.v);
        end
      end
    end
  end

  initial begin
    // Reset two cycles, start on the third
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    idle_step(1'b1);
    idle_step(1'b0);
    idle_step(1'b0);
    // Load-use on rs, then same with rs unused, then on rt
    hz_step(1'b0, 1'b0);
    idle_step(1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 3, 5, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6, 1, 6, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6, 1, 6, 1'b0, 1'b1);
    // LDM, IMM with hazard and ldm forced, back in RUN
    idle_step(1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    hz_step(1'b1, 1'b1);
    idle_step(1'b0);
    // LDM together with hazard stalls first
    hz_step(1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    idle_step(1'b0);
    // Saturation
    for (int k = 0; k < 5; k++) hz_step(1'b0, 1'b0);
    // Halt with hazard, drain, halted, restart
    hz_step(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) idle_step(1'b1 && k == 4);
    idle_step(1'b0);
    // Reset mid-drain
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    idle_step(1'b0);
    idle_step(1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) idle_step(1'b0);
    // Random traffic
    for (int k = 0; k < 800; k++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1);
    end
    stim_done = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
